mux_rr_scheduler: RTL and testbench

Round-robin scheduler that sits directly upstream of `mux_16_to_1` and also consumes its output. It watches 16 per-channel request lines, picks one fairly, and drives the mux `sel`. It then registers the mux output `z` into a valid/ready output stage tagged with the channel number, and pulses a one-hot acknowledge back to the winning source.

---
 rtl/mux_sched_pkg.sv | 28 ++
 rtl/mux_16_to_1.sv | 40 ++++
 rtl/rr_priority_pick.sv | 30 +++
 rtl/mux_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_mux_rr_scheduler.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mux_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sched_pkg
// Description : Shared constants, state encoding and helpers for the
//               round-robin mux scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_sched_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        OUT    = 2'd2
    } sched_state_t;

    // One-hot decode of a channel number.
    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_16_to_1.sv
`default_nettype none
// ============================================================================
// Module      : mux_16_to_1
// Description : Combinational 16:1 word multiplexer selected by sel.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_16_to_1 #(
    parameter int INPUT_BIT_LENGTH = 8
) (
    input  logic [INPUT_BIT_LENGTH-1:0] a, b, c, d, e, f, g, h,
    input  logic [INPUT_BIT_LENGTH-1:0] i, j, k, l, m, n, o, p,
    input  logic [3:0]                  sel,
    output logic [INPUT_BIT_LENGTH-1:0] z
);

    // Pure selection; no state.
    always_comb begin
        z = a;
        case (sel)
            4'd0:  z = a;
            4'd1:  z = b;
            4'd2:  z = c;
            4'd3:  z = d;
            4'd4:  z = e;
            4'd5:  z = f;
            4'd6:  z = g;
            4'd7:  z = h;
            4'd8:  z = i;
            4'd9:  z = j;
            4'd10: z = k;
            4'd11: z = l;
            4'd12: z = m;
            4'd13: z = n;
            4'd14: z = o;
            default: z = p;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Finds the first set request bit at or after ptr, wrapping
//               modulo the channel count. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import mux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    // Scan from the farthest offset down to zero so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_scheduler
// Description : Round-robin scheduler driving an external 16:1 mux select,
//               capturing the mux output into a valid/ready stage tagged with
//               its channel, and pulsing a one-hot ack to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     req,
    output logic [SEL_W-1:0]      sel,
    input  logic [DATA_WIDTH-1:0] mux_z,
    output logic [NUM_CH-1:0]     ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      r_last_grant;
    logic [NUM_CH-1:0]     r_ack;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]      r_out_ch;
    logic                  r_out_valid;

    logic [SEL_W-1:0]      w_ptr;
    logic [NUM_CH-1:0]     w_req_eff;
    logic                  w_found;
    logic [SEL_W-1:0]      w_idx;
    logic                  w_handshake;
    logic                  w_load_sel;

    assign sel       = r_sel;
    assign ack       = r_ack;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

    // While ack is still high the source has not had a chance to drop its
    // request, so its bit is hidden to avoid granting the same word twice.
    assign w_ptr       = r_last_grant + SEL_W'(1);
    assign w_req_eff   = req & ~((r_ack != '0) ? onehot(r_last_grant) : '0);
    assign w_handshake = r_out_valid & out_ready;

    rr_priority_pick u_pick (
        .req   (w_req_eff),
        .ptr   (w_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and select-load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_load_sel  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SAMPLE;
                    w_load_sel  = 1'b1;
                end
            end
            SAMPLE: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                if (w_handshake) begin
                    w_state_nxt = w_found ? SAMPLE : IDLE;
                    w_load_sel  = w_found;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Select, capture stage and ack; ack is a single pulse on entry to OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_last_grant <= SEL_W'(NUM_CH - 1);
            r_ack        <= '0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_load_sel) begin
                r_sel <= w_idx;
            end
            if (r_state == SAMPLE) begin
                r_out_data   <= mux_z;
                r_out_ch     <= r_sel;
                r_out_valid  <= 1'b1;
                r_ack        <= onehot(r_sel);
                r_last_grant <= r_sel;
            end else if (r_state == OUT && w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_scheduler
// Description : Directed self-checking bench for mux_rr_scheduler driving a
//               real mux_16_to_1 loaded with words 8'h01..8'h10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [3:0]  sel;
    logic [7:0]  mux_z;
    logic [15:0] ack;
    logic [7:0]  out_data;
    logic [3:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_16_to_1 #(.INPUT_BIT_LENGTH(8)) u_mux (
        .a(8'h01), .b(8'h02), .c(8'h03), .d(8'h04),
        .e(8'h05), .f(8'h06), .g(8'h07), .h(8'h08),
        .i(8'h09), .j(8'h0A), .k(8'h0B), .l(8'h0C),
        .m(8'h0D), .n(8'h0E), .o(8'h0F), .p(8'h10),
        .sel(sel), .z(mux_z)
    );

    mux_rr_scheduler #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .mux_z(mux_z),
        .ack(ack), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (sel !== 4'd0)       begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel); end
        n_cmp++; if (ack !== 16'h0)      begin n_err++; $display("FAIL reset_ack: got %h want 0000", ack); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
        n_cmp++; if (out_ch !== 4'd0)    begin n_err++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
    endtask

    task automatic test_single();
        req = 16'h0020; out_ready = 1'b1;
        tick();
        n_cmp++; if (sel !== 4'd5)       begin n_err++; $display("FAIL single_sel: got %0d want 5", sel); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1)   begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'h06)   begin n_err++; $display("FAIL single_data: got %h want 06", out_data); end
        n_cmp++; if (out_ch !== 4'd5)      begin n_err++; $display("FAIL single_ch: got %0d want 5", out_ch); end
        n_cmp++; if (ack !== 16'h0020)     begin n_err++; $display("FAIL single_ack: got %h want 0020", ack); end
        // Request still high across the handshake: it must not be re-granted.
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_done: got %b want 0", out_valid); end
        n_cmp++; if (ack !== 16'h0)      begin n_err++; $display("FAIL single_ack_clear: got %h want 0000", ack); end
        req = '0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_no_regrant: got %b want 0", out_valid); end
        n_cmp++; if (sel !== 4'd5)       begin n_err++; $display("FAIL single_sel_hold: got %0d want 5", sel); end
    endtask

    task automatic test_fairness();
        int cnt;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        req = 16'hFFFF; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cnt = 0;
            while (out_valid !== 1'b1 && cnt < 6) begin tick(); cnt++; end
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++; $display("FAIL fair_timeout: word %0d got valid %b want 1", k, out_valid);
            end
            n_cmp++; if (out_ch !== 4'(k % 16)) begin n_err++; $display("FAIL fair_ch: word %0d got %0d want %0d", k, out_ch, k % 16); end
            n_cmp++; if (out_data !== 8'(k % 16 + 1)) begin n_err++; $display("FAIL fair_data: word %0d got %h want %h", k, out_data, 8'(k % 16 + 1)); end
            if (k > 0) begin
                n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL fair_rate: word %0d gap %0d want 1", k, cnt); end
            end
            tick();
        end
        req = '0;
        repeat (4) tick();
    endtask

    task automatic test_backpressure();
        int acks;
        out_ready = 1'b0; req = 16'h0200;
        tick();
        tick();
        req = '0;
        acks = (ack != 16'h0) ? 1 : 0;
        n_cmp++; if (ack !== 16'h0200) begin n_err++; $display("FAIL bp_ack: got %h want 0200", ack); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: cycle %0d got %b want 1", c, out_valid); end
            n_cmp++; if (out_data !== 8'h0A) begin n_err++; $display("FAIL bp_data: cycle %0d got %h want 0A", c, out_data); end
            n_cmp++; if (out_ch !== 4'd9)    begin n_err++; $display("FAIL bp_ch: cycle %0d got %0d want 9", c, out_ch); end
            n_cmp++; if (sel !== 4'd9)       begin n_err++; $display("FAIL bp_sel: cycle %0d got %0d want 9", c, sel); end
            if (c < 4) begin
                tick();
                if (ack != 16'h0) acks++;
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", out_valid); end
        n_cmp++; if (acks !== 1)         begin n_err++; $display("FAIL bp_ack_count: got %0d want 1", acks); end
        tick();
    endtask

    task automatic test_wrap();
        int cnt;
        logic [3:0] exp_ch [3];
        exp_ch[0] = 4'd14; exp_ch[1] = 4'd15; exp_ch[2] = 4'd0;
        out_ready = 1'b1; req = 16'h4000;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            while (out_valid !== 1'b1 && cnt < 6) begin tick(); cnt++; end
            n_cmp++; if (out_ch !== exp_ch[k]) begin n_err++; $display("FAIL wrap_ch: step %0d got %0d want %0d", k, out_ch, exp_ch[k]); end
            n_cmp++; if (out_data !== 8'(exp_ch[k]) + 8'h01) begin n_err++; $display("FAIL wrap_data: step %0d got %h want %h", k, out_data, 8'(exp_ch[k]) + 8'h01); end
            req = (k < 2) ? 16'h8001 : 16'h0000;
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int cnt;
        out_ready = 1'b0; req = 16'h0008;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 6) begin tick(); cnt++; end
        n_cmp++; if (out_ch !== 4'd3) begin n_err++; $display("FAIL rmid_pre_ch: got %0d want 3", out_ch); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        n_cmp++; if (sel !== 4'd0)       begin n_err++; $display("FAIL rmid_sel: got %0d want 0", sel); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h want 00", out_data); end
        n_cmp++; if (out_ch !== 4'd0)    begin n_err++; $display("FAIL rmid_ch: got %0d want 0", out_ch); end
        n_cmp++; if (ack !== 16'h0)      begin n_err++; $display("FAIL rmid_ack: got %h want 0000", ack); end
        req = 16'h8001;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 6) begin tick(); cnt++; end
        n_cmp++; if (out_ch !== 4'd0)    begin n_err++; $display("FAIL rmid_first_ch: got %0d want 0", out_ch); end
        n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL rmid_first_data: got %h want 01", out_data); end
        req = '0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
